swap_sequencer: RTL and testbench

//   Sequences the two-micro-op SWP instruction (swap rs<->rt) through the ID stage.

---
 rtl/swap_sequencer_pkg.sv | 22 ++
 rtl/swap_sequencer.sv | 110 +++++++++++
 tb/tb_swap_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/swap_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// swap_sequencer_pkg
//   Shared pipeline constants for the SWP (swap rs<->rt) instruction.
//   - OP_SWP          : opcode field value (Instruction[31:26]) of SWP
//   - SWP_SEL_*       : writeback destination select encodings, also used by
//                       the ID-stage Dest mux
//   - swp_state_e     : sequencer state encoding
// -----------------------------------------------------------------------------
package swap_sequencer_pkg;

   localparam logic [5:0] OP_SWP = 6'b100100;

   localparam logic [1:0] SWP_SEL_NORMAL = 2'd0;  // Dest from instruction
   localparam logic [1:0] SWP_SEL_SRC1   = 2'd1;  // Dest <- src1 (rs)
   localparam logic [1:0] SWP_SEL_SRC2   = 2'd2;  // Dest <- src2 (rt)

   typedef enum logic {
      IDLE  = 1'b0,
      SWP_B = 1'b1
   } swp_state_e;

endpackage : swap_sequencer_pkg

// File: rtl/swap_sequencer.sv
// -----------------------------------------------------------------------------
// swap_sequencer
//   Splits the SWP instruction into two micro-ops while it sits in ID.
//   uop A writes rs with the rt value and freezes IF/ID so the same word is
//   seen again; uop B writes rt with the old rs value. Both uops read the
//   register file before either writes back, so no extra ordering is needed.
//   A saturating counter records fully issued swaps.
//
// Ports
//   clk             in   1      rising-edge clock
//   rst             in   1      synchronous, active-high reset
//   opcode          in   6      Instruction[31:26] of the word in ID
//   instr_valid     in   1      ID holds a real instruction
//   hazard_detected in   1      ID stalled this cycle by the hazard unit
//   flush           in   1      taken branch, ID contents discarded
//   freeze          out  1      hold PC and IF/ID this cycle
//   swp_sel         out  2      writeback destination select (0/1/2)
//   busy            out  1      second micro-op pending (state SWP_B)
//   swp_count       out  CNT_W  completed swaps, saturating
// -----------------------------------------------------------------------------
module swap_sequencer
   import swap_sequencer_pkg::*;
#(
   parameter logic [5:0] SWP_OPCODE = OP_SWP,
   parameter int         CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic             instr_valid,
   input  logic             hazard_detected,
   input  logic             flush,
   output logic             freeze,
   output logic [1:0]       swp_sel,
   output logic             busy,
   output logic [CNT_W-1:0] swp_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   swp_state_e       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             is_swp;
   logic             swap_done;

   assign is_swp = instr_valid & (opcode == SWP_OPCODE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Mealy next-state/output logic. flush wins over everything: a half-issued
   // swap is dropped and uop A is squashed downstream by the same flush.
   always_comb begin
      state_d   = state_q;
      freeze    = 1'b0;
      swp_sel   = SWP_SEL_NORMAL;
      busy      = (state_q == SWP_B);
      swap_done = 1'b0;

      if (flush) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               // With a hazard nothing issues; the stalled SWP retries later.
               if (is_swp && !hazard_detected) begin
                  freeze  = 1'b1;
                  swp_sel = SWP_SEL_SRC1;
                  state_d = SWP_B;
               end
            end
            SWP_B: begin
               // IF/ID is frozen here, so opcode/instr_valid are not consulted.
               swp_sel = SWP_SEL_SRC2;
               if (hazard_detected) begin
                  freeze = 1'b1;
               end else begin
                  swap_done = 1'b1;
                  state_d   = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      count_d = count_q;
      if (swap_done && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign swp_count = count_q;

endmodule : swap_sequencer

// File: tb/tb_swap_sequencer.sv
// -----------------------------------------------------------------------------
// tb_swap_sequencer
//   Two instances share one stimulus: a default-width counter and a 2-bit
//   counter for saturation. A directed vector table, a hand-written
//   back-to-back saturation sequence and a randomized run against a
//   behavioural model exercise the sequencer.
// -----------------------------------------------------------------------------
module tb_swap_sequencer;

   localparam logic [5:0] SWP = 6'b100100;
   localparam logic [5:0] ADD = 6'b000000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  opcode = '0;
   logic        instr_valid = 1'b0;
   logic        hazard_detected = 1'b0;
   logic        flush = 1'b0;

   logic        freeze, freeze_s;
   logic [1:0]  swp_sel, swp_sel_s;
   logic        busy, busy_s;
   logic [15:0] swp_count;
   logic [1:0]  swp_count_s;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   swap_sequencer #(.SWP_OPCODE(SWP), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .instr_valid(instr_valid),
      .hazard_detected(hazard_detected), .flush(flush),
      .freeze(freeze), .swp_sel(swp_sel), .busy(busy), .swp_count(swp_count)
   );

   swap_sequencer #(.SWP_OPCODE(SWP), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .opcode(opcode), .instr_valid(instr_valid),
      .hazard_detected(hazard_detected), .flush(flush),
      .freeze(freeze_s), .swp_sel(swp_sel_s), .busy(busy_s), .swp_count(swp_count_s)
   );

   typedef struct {
      bit         r;
      logic [5:0] op;
      bit         v;
      bit         h;
      bit         f;
      bit         chk;
      bit         e_frz;
      int         e_sel;
      bit         e_busy;
      int         e_cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit r, logic [5:0] op, bit v, bit h, bit f,
                               bit chk, bit ef, int es, bit eb, int ec);
      vec_t t;
      t.r = r; t.op = op; t.v = v; t.h = h; t.f = f; t.chk = chk;
      t.e_frz = ef; t.e_sel = es; t.e_busy = eb; t.e_cnt = ec;
      return t;
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input bit r, input logic [5:0] op, input bit v,
                        input bit h, input bit f);
      rst = r; opcode = op; instr_valid = v; hazard_detected = h; flush = f;
   endtask

   // Advance past the next rising edge; inputs change 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Behavioural reference: a swap is two uops; track how many of the
   // current swap's uops have gone out and how many swaps completed.
   int  uops_out;
   int  done_swaps;
   int  done_sat;
   bit  m_frz;
   int  m_sel;
   bit  m_busy;
   bit  m_done;

   task automatic model_outputs(input logic [5:0] op, input bit v, input bit h,
                                input bit f);
      m_frz  = 1'b0;
      m_sel  = 0;
      m_busy = (uops_out == 1);
      m_done = 1'b0;
      if (!f) begin
         if (uops_out == 1) begin
            m_sel  = 2;
            m_frz  = h;
            m_done = !h;
         end else if (v && op == SWP && !h) begin
            m_sel = 1;
            m_frz = 1'b1;
         end
      end
   endtask

   task automatic model_clock(input bit r, input bit f);
      if (r) begin
         uops_out   = 0;
         done_swaps = 0;
         done_sat   = 0;
      end else if (f) begin
         uops_out = 0;
      end else if (m_done) begin
         uops_out   = 0;
         done_swaps = done_swaps + 1;
         done_sat   = (done_sat < 3) ? done_sat + 1 : 3;
      end else if (m_sel == 1) begin
         uops_out = 1;
      end
   endtask

   initial begin
      // ---- directed table ----
      tbl.push_back(mk(1, ADD, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, ADD, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, ADD, 0, 0, 0, 1, 0, 0, 0, 0));   // reset state
      tbl.push_back(mk(0, SWP, 1, 0, 0, 1, 1, 1, 0, 0));   // plain: uop A
      tbl.push_back(mk(0, SWP, 1, 0, 0, 1, 0, 2, 1, 0));   //        uop B
      tbl.push_back(mk(0, ADD, 0, 0, 0, 1, 0, 0, 0, 1));
      tbl.push_back(mk(0, SWP, 1, 1, 0, 1, 0, 0, 0, 1));   // hazard at entry
      tbl.push_back(mk(0, SWP, 1, 1, 0, 1, 0, 0, 0, 1));
      tbl.push_back(mk(0, SWP, 1, 0, 0, 1, 1, 1, 0, 1));
      tbl.push_back(mk(0, SWP, 1, 0, 0, 1, 0, 2, 1, 1));
      tbl.push_back(mk(0, ADD, 0, 0, 0, 1, 0, 0, 0, 2));
      tbl.push_back(mk(0, SWP, 1, 0, 0, 1, 1, 1, 0, 2));   // hazard in B
      tbl.push_back(mk(0, SWP, 1, 1, 0, 1, 1, 2, 1, 2));
      tbl.push_back(mk(0, ADD, 0, 1, 0, 1, 1, 2, 1, 2));   // opcode ignored in B
      tbl.push_back(mk(0, SWP, 1, 1, 0, 1, 1, 2, 1, 2));
      tbl.push_back(mk(0, SWP, 1, 0, 0, 1, 0, 2, 1, 2));
      tbl.push_back(mk(0, ADD, 0, 0, 0, 1, 0, 0, 0, 3));
      tbl.push_back(mk(0, SWP, 1, 0, 0, 1, 1, 1, 0, 3));   // flush mid-swap
      tbl.push_back(mk(0, SWP, 1, 1, 1, 1, 0, 0, 1, 3));
      tbl.push_back(mk(0, ADD, 1, 0, 0, 1, 0, 0, 0, 3));
      tbl.push_back(mk(0, SWP, 1, 0, 1, 1, 0, 0, 0, 3));   // flush at entry
      tbl.push_back(mk(0, ADD, 0, 0, 0, 1, 0, 0, 0, 3));
      tbl.push_back(mk(0, SWP, 0, 0, 0, 1, 0, 0, 0, 3));   // bubble with SWP bits
      tbl.push_back(mk(0, SWP, 1, 0, 0, 1, 1, 1, 0, 3));   // reset mid-swap
      tbl.push_back(mk(1, SWP, 1, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, ADD, 0, 0, 0, 1, 0, 0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].r, tbl[i].op, tbl[i].v, tbl[i].h, tbl[i].f);
         @(negedge clk);
         if (tbl[i].chk) begin
            check($sformatf("tbl%0d.freeze", i), int'(freeze), int'(tbl[i].e_frz));
            check($sformatf("tbl%0d.swp_sel", i), int'(swp_sel), tbl[i].e_sel);
            check($sformatf("tbl%0d.busy", i), int'(busy), int'(tbl[i].e_busy));
            check($sformatf("tbl%0d.count", i), int'(swp_count), tbl[i].e_cnt);
            check($sformatf("tbl%0d.count_sat", i), int'(swp_count_s),
                  (tbl[i].e_cnt > 3) ? 3 : tbl[i].e_cnt);
         end
         step();
      end

      // ---- saturation: 5 back-to-back SWPs on the 2-bit counter ----
      drive(1, ADD, 0, 0, 0);
      step();
      for (int k = 0; k < 5; k++) begin
         drive(0, SWP, 1, 0, 0);
         @(negedge clk);
         check($sformatf("sat%0d.A.sel", k), int'(swp_sel_s), 1);
         check($sformatf("sat%0d.A.freeze", k), int'(freeze_s), 1);
         step();
         @(negedge clk);
         check($sformatf("sat%0d.B.sel", k), int'(swp_sel_s), 2);
         check($sformatf("sat%0d.B.busy", k), int'(busy_s), 1);
         step();
         check($sformatf("sat%0d.count_sat", k), int'(swp_count_s), (k + 1 > 3) ? 3 : k + 1);
         check($sformatf("sat%0d.count", k), int'(swp_count), k + 1);
      end
      drive(0, ADD, 1, 0, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("sat.nonswp.freeze", int'(freeze_s), 0);
         step();
      end
      check("sat.nonswp.count", int'(swp_count_s), 3);

      // ---- randomized run against the behavioural model ----
      drive(1, ADD, 0, 0, 0);
      step();
      uops_out = 0; done_swaps = 0; done_sat = 0;
      for (int n = 0; n < 3000; n++) begin
         bit         r, v, h, f;
         logic [5:0] op;
         r  = ($urandom_range(0, 99) == 0);
         op = ($urandom_range(0, 2) != 0) ? SWP : 6'($urandom);
         v  = ($urandom_range(0, 7) != 0);
         h  = ($urandom_range(0, 3) == 0);
         f  = ($urandom_range(0, 9) == 0);
         drive(r, op, v, h, f);
         model_outputs(op, v, h, f);
         @(negedge clk);
         check("rnd.freeze", int'(freeze), int'(m_frz));
         check("rnd.swp_sel", int'(swp_sel), m_sel);
         check("rnd.busy", int'(busy), int'(m_busy));
         check("rnd.count", int'(swp_count), done_swaps);
         check("rnd.count_sat", int'(swp_count_s), done_sat);
         check("rnd.sat.swp_sel", int'(swp_sel_s), m_sel);
         model_clock(r, f);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_swap_sequencer
